// File: rtl/button_pkg.sv
// Shared constants, types and sizing helpers for the button debouncer slice.
package button_pkg;

  localparam int DEBOUNCE_10MS_50MHZ = 500000;
  localparam int REPEAT_DELAY_DEF    = 25000000;
  localparam int REPEAT_PERIOD_DEF   = 10000000;

  // Per-channel result bundle; "rel" because release is a reserved word.
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
  } btn_event_t;

  typedef enum logic {
    REP_FIRST,
    REP_PERIODIC
  } rep_phase_t;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

  // The repeat counter must hold the larger of the two intervals, and never be zero bits wide.
  function automatic int rep_cnt_width(input int delay, input int period);
    int span;
    span = (delay > period) ? delay : period;
    if (span < 2) begin
      span = 2;
    end
    return cnt_width(span);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle between the raw pins, the debouncer and its consumers.
interface button_debouncer_if #(
  parameter int NUM_BTN = 4
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, stability counter, level and edge pulses.
// Auto-repeat of the press pulse is built only when BUTTON_DEBOUNCER_REPEAT_EN is defined.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw,
  output btn_event_t ev
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE_CYCLES must be >= 2");
  end

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_channel: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          press;
  logic          rel;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync2 != level) && (cnt == CNT_LAST);

  // raw is already active-high; reset value 0 means "released"
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Counter only advances while the sample disagrees with the accepted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rel   <= 1'b0;
    end else begin
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      rel <= accept & ~sync2;
    end
  end

`ifdef BUTTON_DEBOUNCER_REPEAT_EN

  localparam int RW = rep_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RW-1:0] REP_FIRST_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  rep_phase_t    rep_phase;
  logic [RW-1:0] rep_cnt;
  logic          rep_fire;

  // An accepted release always wins, so no repeat pulse lands on the release edge
  assign rep_fire = level && !accept &&
                    (rep_cnt == ((rep_phase == REP_FIRST) ? REP_FIRST_LAST : REP_PERIOD_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_phase <= REP_FIRST;
      rep_cnt   <= '0;
    end else if (accept || !level) begin
      rep_phase <= REP_FIRST;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_phase <= REP_PERIODIC;
      rep_cnt   <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press <= 1'b0;
    end else begin
      press <= accept ? sync2 : rep_fire;
    end
  end

`else

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press <= 1'b0;
    end else begin
      press <= accept & sync2;
    end
  end

`endif

  assign ev = '{level: level, press: press, rel: rel};

endmodule

// File: rtl/button_debouncer.sv
// Debounces NUM_BTN raw push-buttons into a clean level vector plus press/release pulses.
// Define BUTTON_DEBOUNCER_REPEAT_EN to add auto-repeat press pulses while a button is held.
module button_debouncer
  import button_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
  parameter int RAW_ACTIVE_LOW  = 1,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input logic                clk,
  input logic                reset,
  button_debouncer_if.slave  bus
);

  btn_event_t ev [NUM_BTN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic raw_norm;

    // Normalise to active-high before the synchronizer so everything downstream sees 1 = pressed
    assign raw_norm = (RAW_ACTIVE_LOW != 0) ? ~bus.btn_raw[i] : bus.btn_raw[i];

    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_norm),
      .ev    (ev[i])
    );
  end

  always_comb begin
    bus.btn_level   = '0;
    bus.btn_press   = '0;
    bus.btn_release = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      bus.btn_level[i]   = ev[i].level;
      bus.btn_press[i]   = ev[i].press;
      bus.btn_release[i] = ev[i].rel;
    end
  end

endmodule
